// File: rtl/branch_predict_table_if.sv
// Fetch/execute-side signal bundle for branch_predict_table.
// The master side drives lookups, resolved-branch records and flush; the slave side is the table.
interface branch_predict_table_if;
    // Handshake: lookup_en and upd_valid are single-cycle qualifiers with no back-pressure.
    // A lookup sampled on an edge returns pred_* after that edge, and pred_* holds while lookup_en is low.
    // Updates are accepted only while ready=1 and flush=0; otherwise they are silently dropped.
    logic        flush;
    logic        ready;
    logic        lookup_en;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [1:0]  pred_counter;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [1:0]  upd_counter;
    logic        upd_is_cond;

    modport master (
        output flush, lookup_en, lookup_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_counter, upd_is_cond,
        input  ready, pred_valid, pred_taken, pred_target, pred_counter
    );

    modport slave (
        input  flush, lookup_en, lookup_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_counter, upd_is_cond,
        output ready, pred_valid, pred_taken, pred_target, pred_counter
    );
endinterface

// File: rtl/branch_predict_table.sv
// Direct-mapped BTB with 2-bit bimodal counters, self-clearing after reset and flush.
// Define BPU_TAG_CHECK_EN to store and compare tags (pc[31:IDX_W+2]); tagless otherwise.
module branch_predict_table #(
    parameter int DEPTH = 512,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_predict_table_if.slave  bus
);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam int         TAG_W    = 32 - IDX_W - 2;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

    logic             valid_q   [DEPTH];
    logic [29:0]      target_q  [DEPTH];
    logic [1:0]       counter_q [DEPTH];
    logic             uncond_q  [DEPTH];
`ifdef BPU_TAG_CHECK_EN
    logic [TAG_W-1:0] tag_q     [DEPTH];
`endif

    logic             pred_valid_q, pred_taken_q;
    logic [31:0]      pred_target_q;
    logic [1:0]       pred_counter_q;

    logic [IDX_W-1:0] upd_idx, lk_idx;
    logic [TAG_W-1:0] upd_tag, lk_tag;
    logic             in_ready, upd_go, upd_hit;
    logic             wr_en, wr_valid, wr_uncond;
    logic [29:0]      wr_target;
    logic [1:0]       wr_counter;
    logic             fwd, lk_valid, lk_uncond, lk_hit;
    logic [29:0]      lk_target;
    logic [1:0]       lk_counter;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'd3) ? 2'd3 : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    assign upd_idx  = bus.upd_pc[IDX_W+1:2];
    assign lk_idx   = bus.lookup_pc[IDX_W+1:2];
    assign upd_tag  = bus.upd_pc[31:IDX_W+2];
    assign lk_tag   = bus.lookup_pc[31:IDX_W+2];
    assign in_ready = (state_q == ST_READY);
    assign upd_go   = in_ready & bus.upd_valid & ~bus.flush;

`ifdef BPU_TAG_CHECK_EN
    assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.upd_pc[1:0], bus.lookup_pc[1:0], bus.upd_target[1:0]};
`else
    assign upd_hit = valid_q[upd_idx];
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.upd_pc[1:0], bus.lookup_pc[1:0], bus.upd_target[1:0],
                              upd_tag, lk_tag};
`endif

    // Resolve the entry image an accepted update would write; reused for write-forwarding.
    always_comb begin
        wr_en      = 1'b0;
        wr_valid   = valid_q[upd_idx];
        wr_target  = target_q[upd_idx];
        wr_counter = counter_q[upd_idx];
        wr_uncond  = uncond_q[upd_idx];
        if (upd_go) begin
            if (!bus.upd_is_cond) begin
                wr_en      = 1'b1;
                wr_valid   = 1'b1;
                wr_uncond  = 1'b1;
                wr_counter = 2'd3;
                wr_target  = bus.upd_target[31:2];
            end else if (bus.upd_taken) begin
                wr_en      = 1'b1;
                wr_valid   = 1'b1;
                wr_uncond  = 1'b0;
                wr_counter = sat_inc(bus.upd_counter);
                wr_target  = bus.upd_target[31:2];
            end else if (upd_hit) begin
                wr_en      = 1'b1;
                wr_counter = sat_dec(bus.upd_counter);
            end
        end
    end

    always_comb begin
        fwd        = wr_en && (upd_idx == lk_idx);
        lk_valid   = fwd ? wr_valid   : valid_q[lk_idx];
        lk_target  = fwd ? wr_target  : target_q[lk_idx];
        lk_counter = fwd ? wr_counter : counter_q[lk_idx];
        lk_uncond  = fwd ? wr_uncond  : uncond_q[lk_idx];
`ifdef BPU_TAG_CHECK_EN
        lk_hit     = lk_valid & (fwd ? (upd_tag == lk_tag) : (tag_q[lk_idx] == lk_tag));
`else
        lk_hit     = lk_valid;
`endif
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (bus.flush) begin
            state_d   = ST_CLEAR;
            clr_idx_d = '0;
        end else if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + IDX_W'(1);
            if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_READY;
        end
    end

    // Table storage has no reset; the CLEAR sweep is what invalidates it.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR && !bus.flush) begin
            valid_q[clr_idx_q] <= 1'b0;
        end else if (wr_en) begin
            valid_q[upd_idx]   <= wr_valid;
            target_q[upd_idx]  <= wr_target;
            counter_q[upd_idx] <= wr_counter;
            uncond_q[upd_idx]  <= wr_uncond;
`ifdef BPU_TAG_CHECK_EN
            tag_q[upd_idx]     <= upd_tag;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_CLEAR;
            clr_idx_q      <= '0;
            pred_valid_q   <= 1'b0;
            pred_taken_q   <= 1'b0;
            pred_target_q  <= '0;
            pred_counter_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            if (bus.lookup_en) begin
                if (in_ready && lk_hit) begin
                    pred_valid_q   <= 1'b1;
                    pred_taken_q   <= lk_uncond | lk_counter[1];
                    pred_target_q  <= {lk_target, 2'b00};
                    pred_counter_q <= lk_counter;
                end else begin
                    pred_valid_q   <= 1'b0;
                    pred_taken_q   <= 1'b0;
                    pred_target_q  <= '0;
                    pred_counter_q <= '0;
                end
            end
        end
    end

    assign bus.ready        = in_ready;
    assign bus.pred_valid   = pred_valid_q;
    assign bus.pred_taken   = pred_taken_q;
    assign bus.pred_target  = pred_target_q;
    assign bus.pred_counter = pred_counter_q;
endmodule

// File: tb/tb_branch_predict_table.sv
// Directed bench for branch_predict_table: lookups push expected predictions, a monitor compares them.
module tb_branch_predict_table;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cycles;
    logic lk_prev = 1'b0;
    logic [35:0] exp_q[$];

    branch_predict_table_if bus();

    branch_predict_table #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [35:0] pred(input logic v, input logic t, input logic [31:0] tg,
                                         input logic [1:0] c);
        return {v, t, tg, c};
    endfunction

    function automatic logic [35:0] dut_pred();
        return {bus.pred_valid, bus.pred_taken, bus.pred_target, bus.pred_counter};
    endfunction

    // Monitor: a lookup sampled on the last edge has a result to compare now.
    always @(posedge clk) lk_prev <= bus.lookup_en & ~rst;

    always @(negedge clk) begin
        if (lk_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_lookup_result", dut_pred(), '0);
                if (dut_pred() === '0) begin
                    n_pass--;
                    $display("FAIL unexpected_lookup_result: got result expected none");
                end
            end else begin
                check("lookup", dut_pred(), exp_q.pop_front());
            end
        end
    end

    task automatic idle();
        bus.lookup_en = 1'b0;
        bus.upd_valid = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic [1:0] ctr, input logic cond);
        bus.upd_valid   = 1'b1;
        bus.upd_pc      = pc;
        bus.upd_taken   = tk;
        bus.upd_target  = tgt;
        bus.upd_counter = ctr;
        bus.upd_is_cond = cond;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                             input logic [1:0] ctr, input logic cond);
        set_upd(pc, tk, tgt, ctr, cond);
        @(negedge clk);
        bus.upd_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc, input logic [35:0] exp);
        bus.lookup_en = 1'b1;
        bus.lookup_pc = pc;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.lookup_en = 1'b0;
    endtask

    task automatic do_both(input logic [31:0] lpc, input logic [35:0] exp,
                           input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic [1:0] ctr, input logic cond);
        bus.lookup_en = 1'b1;
        bus.lookup_pc = lpc;
        exp_q.push_back(exp);
        set_upd(pc, tk, tgt, ctr, cond);
        @(negedge clk);
        bus.lookup_en = 1'b0;
        bus.upd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 1'b0;
        bus.lookup_en = 1'b0;
        bus.lookup_pc = '0;
        bus.upd_valid = 1'b0;
        bus.upd_pc = '0;
        bus.upd_taken = 1'b0;
        bus.upd_target = '0;
        bus.upd_counter = '0;
        bus.upd_is_cond = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_pred", dut_pred(), '0);
        check("reset_ready", {35'd0, bus.ready}, '0);
        rst = 1'b0;

        // Lookup every cycle through the post-reset sweep.
        cycles = 0;
        while (!bus.ready && cycles < 2000) begin
            bus.lookup_en = 1'b1;
            bus.lookup_pc = 32'h8000_0100;
            exp_q.push_back('0);
            @(negedge clk);
            cycles++;
        end
        bus.lookup_en = 1'b0;
        check("reset_clear_cycles", 36'(cycles), 36'(DEPTH));

        do_update(32'h8000_0100, 1'b1, 32'h8000_0200, 2'd1, 1'b1);
        do_lookup(32'h8000_0100, pred(1, 1, 32'h8000_0200, 2'd2));
        do_update(32'h8000_0100, 1'b0, 32'h0, 2'd3, 1'b1);
        do_lookup(32'h8000_0100, pred(1, 1, 32'h8000_0200, 2'd2));
        do_update(32'h8000_0100, 1'b0, 32'h0, 2'd2, 1'b1);
        do_lookup(32'h8000_0100, pred(1, 0, 32'h8000_0200, 2'd1));
        do_update(32'h8000_0100, 1'b0, 32'h0, 2'd1, 1'b1);
        do_lookup(32'h8000_0100, pred(1, 0, 32'h8000_0200, 2'd0));
        do_update(32'h8000_0100, 1'b0, 32'h0, 2'd0, 1'b1);
        do_lookup(32'h8000_0100, pred(1, 0, 32'h8000_0200, 2'd0));

        do_update(32'h8000_0400, 1'b0, 32'h8000_0800, 2'd1, 1'b1);
        do_lookup(32'h8000_0400, '0);
        do_update(32'h8000_0500, 1'b1, 32'h8000_1000, 2'd0, 1'b0);
        do_lookup(32'h8000_0500, pred(1, 1, 32'h8000_1000, 2'd3));

        do_both(32'h8000_0040, pred(1, 0, 32'h8000_0AB4, 2'd1),
                32'h8000_0040, 1'b1, 32'h8000_0AB4, 2'd0, 1'b1);
        do_update(32'h8000_0040, 1'b1, 32'h8000_0AB8, 2'd3, 1'b1);
        do_lookup(32'h8000_0040, pred(1, 1, 32'h8000_0AB8, 2'd3));
        do_both(32'h8000_0100, pred(1, 0, 32'h8000_0200, 2'd0),
                32'h8000_0600, 1'b1, 32'h8000_2000, 2'd1, 1'b0);
        do_lookup(32'h8000_0600, pred(1, 1, 32'h8000_2000, 2'd3));

`ifdef BPU_TAG_CHECK_EN
        do_lookup(32'h8000_0900, '0);
        repeat (3) idle();
        check("hold_after_idle", dut_pred(), '0);
`else
        do_lookup(32'h8000_0900, pred(1, 0, 32'h8000_0200, 2'd0));
        repeat (3) idle();
        check("hold_after_idle", dut_pred(), pred(1, 0, 32'h8000_0200, 2'd0));
`endif

        // Flush with a same-cycle update, then a dropped update mid-sweep.
        bus.flush = 1'b1;
        set_upd(32'h8000_0700, 1'b1, 32'h8000_3000, 2'd1, 1'b1);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.upd_valid = 1'b0;
        check("ready_after_flush", {35'd0, bus.ready}, '0);
        cycles = 0;
        while (!bus.ready && cycles < 2000) begin
            if (cycles == 300) set_upd(32'h8000_0000, 1'b1, 32'h8000_0300, 2'd1, 1'b1);
            else bus.upd_valid = 1'b0;
            @(negedge clk);
            cycles++;
        end
        bus.upd_valid = 1'b0;
        check("flush_clear_cycles", 36'(cycles), 36'(DEPTH));
        do_lookup(32'h8000_0700, '0);
        do_lookup(32'h8000_0000, '0);
        do_lookup(32'h8000_0100, '0);

        repeat (2) idle();
        check("scoreboard_drained", 36'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_predict_table.md
Name: branch_predict_table

Overview:
Direct-mapped branch target buffer plus 2-bit bimodal history table.
- Fetch side: looked up by fetch PC; returns prediction fields (valid, taken, target, counter) one cycle later.
- Execute side: trained by resolved-branch records (pc, taken, target, counter, conditional/unconditional) produced at execute, i.e. the consumer end of the resolved-branch interface.
- Owns its own table-clear sequencing after reset and after flush.

Parameters:
DEPTH, 512, number of entries; power of two, at least 2.
IDX_W, $clog2(DEPTH), index width; index = pc[IDX_W+1:2].

Ports:
clk  input  1  clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  one-cycle pulse; invalidates the whole table (re-enters CLEAR).
ready  output  1  1 when in READY state.
lookup_en  input  1  lookup request this cycle.
lookup_pc  input  32  fetch PC; bits [1:0] ignored.
pred_valid  output  1  registered; lookup hit on a valid entry.
pred_taken  output  1  registered; predicted direction.
pred_target  output  32  registered; predicted target, bits [1:0] = 0.
pred_counter  output  2  registered; entry counter (0 on miss).
upd_valid  input  1  resolved-branch record valid.
upd_pc  input  32  branch PC.
upd_taken  input  1  resolved direction.
upd_target  input  32  resolved target.
upd_counter  input  2  counter value delivered with the original prediction.
upd_is_cond  input  1  1 = conditional branch, 0 = unconditional jump (J/JAL/JR/JALR).

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Entry fields: valid, target[31:2], counter[1:0], uncond. Tag field exists only with the optional feature.
- Reset (async):
  - all pred_* outputs = 0; ready = 0.
  - state = CLEAR; clear index = 0.
  - Entry contents are not reset directly; the CLEAR sweep invalidates them.
- CLEAR state:
  - Each cycle: entry[clear index].valid <= 0; clear index increments.
  - After writing index DEPTH-1, go to READY. CLEAR lasts exactly DEPTH cycles.
  - Updates are dropped.
  - Lookups produce pred_valid = 0 with other pred_* = 0 on the next cycle.
- READY state:
  - flush=1 → CLEAR with clear index = 0. The same-cycle update is dropped.
  - flush during CLEAR restarts the sweep at index 0.
- Lookup (READY, lookup_en=1), result registered, 1-cycle latency:
  - hit = entry.valid (and tag match if the feature is on).
  - pred_valid = hit; pred_target = {entry.target, 2'b00}; pred_counter = entry.counter.
  - pred_taken = hit & (entry.uncond | entry.counter[1]).
  - Miss: all pred_* = 0.
  - lookup_en = 0: pred_* hold their previous values.
- Update (READY, upd_valid=1, flush=0), written at the clock edge:
  - Conditional, taken: counter = sat_inc(upd_counter), saturating at 3; target = upd_target[31:2]; valid = 1; uncond = 0.
  - Conditional, not taken, entry currently hits: counter = sat_dec(upd_counter), saturating at 0; target unchanged.
  - Conditional, not taken, entry misses: no write, no allocation.
  - Unconditional: valid = 1; uncond = 1; counter = 3; target = upd_target[31:2].
  - Update to a valid entry with a different PC (aliasing) overwrites it per the rules above. For a not-taken miss, nothing is written.
- Same cycle lookup_en and upd_valid to the same index: the lookup result reflects the entry as written by that update (write-forwarding).
- Lookup and update to different indices in the same cycle: fully independent.
- Upper target bits are stored verbatim; no arithmetic beyond 2-bit saturation.

Optional Feature:
BPU_TAG_CHECK_EN
- Defined: each entry also stores tag = pc[31:IDX_W+2].
  - hit = valid & tag match.
  - Taken/unconditional updates write the tag.
  - Not-taken updates decrement only on a tag match.
- Undefined: tagless; hit = valid; no tag storage.

Test Plan:
- Reset with DEPTH=512, lookup every cycle → ready rises exactly 512 cycles after rst deasserts; every lookup during CLEAR gives pred_valid=0.
- Update pc=0x8000_0100, cond, taken, target=0x8000_0200, counter=1; then lookup 0x8000_0100 → pred_valid=1, taken=1, target=0x8000_0200, counter=2.
- Same entry: three not-taken updates with counter 3, 2, 1 → counters 2, 1, 0; lookup gives taken=0, counter=0. A further not-taken update with counter=0 keeps 0.
- Not-taken conditional update on an empty index → no allocation; lookup pred_valid=0. Unconditional JAL update → counter=3, taken=1.
- Same-cycle lookup and taken update to pc 0x8000_0040 → next-cycle pred_valid=1 with the new target. Flush pulse → ready=0 for 512 cycles; an update in the flush cycle is dropped.
- With BPU_TAG_CHECK_EN: train 0x8000_0100, look up alias 0x8000_0900 (same index, DEPTH=512) → pred_valid=0. Without the macro → pred_valid=1.
